// File: rtl/mips_cpu_bus_mem_pkg.sv
// Shared definitions for the load/store bus access unit: size codes,
// request-op bit positions, FSM states and access-width helpers.
package mips_cpu_bus_mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam int unsigned OP_STORE_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'b00,
        ACC_HALF = 2'b01,
        ACC_WORD = 2'b10
    } acc_t;

    // Unsigned codes share the width of their signed twin; unused codes fall back to word.
    function automatic acc_t acc_of(input logic [2:0] sz);
        acc_t a;
        case (sz)
            SZ_B, SZ_BU: a = ACC_BYTE;
            SZ_H, SZ_HU: a = ACC_HALF;
            SZ_W:        a = ACC_WORD;
            default:     a = ACC_WORD;
        endcase
        return a;
    endfunction

    function automatic logic is_misaligned(input acc_t a, input logic [1:0] lo);
        logic m;
        case (a)
            ACC_BYTE: m = 1'b0;
            ACC_HALF: m = lo[0];
            default:  m = (lo != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mips_cpu_bus_load_extend.sv
// Selects the addressed byte/halfword lane of a bus read word and
// sign- or zero-extends it to 32 bits according to the load size code.
module mips_cpu_bus_load_extend
    import mips_cpu_bus_mem_pkg::*;
(
    input  logic [31:0] readdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection
    always_comb begin
        byte_s = 8'd0;
        half_s = 16'd0;
        case (addr_lo)
            2'd0:    byte_s = readdata[7:0];
            2'd1:    byte_s = readdata[15:8];
            2'd2:    byte_s = readdata[23:16];
            2'd3:    byte_s = readdata[31:24];
            default: byte_s = 8'd0;
        endcase
        if (addr_lo[1]) begin
            half_s = readdata[31:16];
        end else begin
            half_s = readdata[15:0];
        end
    end

    // Extension; anything that is not a byte/half code passes the word through
    always_comb begin
        rdata_ext = readdata;
        case (size)
            SZ_B:    rdata_ext = {{24{byte_s[7]}}, byte_s};
            SZ_BU:   rdata_ext = {24'd0, byte_s};
            SZ_H:    rdata_ext = {{16{half_s[15]}}, half_s};
            SZ_HU:   rdata_ext = {16'd0, half_s};
            default: rdata_ext = readdata;
        endcase
    end

endmodule

// File: rtl/mips_cpu_bus_mem_access.sv
// Load/store access unit: turns one CPU memory request at a time into a
// word-aligned Avalon-style bus cycle and returns an extended load result.
module mips_cpu_bus_mem_access
    import mips_cpu_bus_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_t      state_r;
    logic [2:0]  size_r;
    logic [1:0]  addr_lo_r;
    logic        store_r;

    logic        accept_s;
    logic        store_s;
    logic        misaligned_s;
    acc_t        acc_s;
    logic [3:0]  be_s;
    logic [31:0] wd_s;
    logic [31:0] ext_s;

    assign accept_s     = req_valid && req_ready;
    assign store_s      = req_op[OP_STORE_BIT];
    assign acc_s        = acc_of(req_op[2:0]);
    assign misaligned_s = is_misaligned(acc_s, req_addr[1:0]);

    // Store lane steering and byte enables for the incoming request
    always_comb begin
        be_s = 4'b1111;
        wd_s = req_wdata;
        case (acc_s)
            ACC_BYTE: begin
                be_s = 4'b0001 << req_addr[1:0];
                wd_s = {4{req_wdata[7:0]}};
            end
            ACC_HALF: begin
                be_s = 4'b0011 << {req_addr[1], 1'b0};
                wd_s = {2{req_wdata[15:0]}};
            end
            default: begin
                be_s = 4'b1111;
                wd_s = req_wdata;
            end
        endcase
    end

    mips_cpu_bus_load_extend u_load_extend (
        .readdata  (readdata),
        .addr_lo   (addr_lo_r),
        .size      (size_r),
        .rdata_ext (ext_s)
    );

    // Transaction FSM; bus and response outputs are all registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            size_r         <= 3'd0;
            addr_lo_r      <= 2'd0;
            store_r        <= 1'b0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'd0;
            rsp_misaligned <= 1'b0;
            address        <= 32'd0;
            read           <= 1'b0;
            write          <= 1'b0;
            writedata      <= 32'd0;
            byteenable     <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (accept_s) begin
                        size_r    <= req_op[2:0];
                        addr_lo_r <= req_addr[1:0];
                        store_r   <= store_s;
                        req_ready <= 1'b0;
                        if (misaligned_s) begin
                            // Fault is reported without touching the bus
                            state_r        <= ST_RESP;
                            rsp_valid      <= 1'b1;
                            rsp_misaligned <= 1'b1;
                            rsp_rdata      <= 32'd0;
                        end else begin
                            state_r    <= ST_BUS;
                            address    <= {req_addr[31:2], 2'b00};
                            byteenable <= be_s;
                            writedata  <= wd_s;
                            read       <= ~store_s;
                            write      <= store_s;
                        end
                    end
                end
                ST_BUS: begin
                    if (!waitrequest) begin
                        read           <= 1'b0;
                        write          <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_misaligned <= 1'b0;
                        rsp_rdata      <= store_r ? 32'd0 : ext_s;
                        state_r        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    read      <= 1'b0;
                    write     <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_mem_access.sv
// Scoreboard bench: stimulus pushes expected bus cycles and responses,
// a bus-slave process and a response monitor pop and compare them.
module tb_mips_cpu_bus_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          wr;
        int          waits;
        logic [31:0] rdword;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        bit          mis;
        int          cyc;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;
    logic [2:0] codes [5] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};

    mips_cpu_bus_mem_access dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .address        (address),
        .read           (read),
        .write          (write),
        .waitrequest    (waitrequest),
        .writedata      (writedata),
        .byteenable     (byteenable),
        .readdata       (readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] code);
        if (code[1:0] == 2'b00) return 1;
        if (code[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Reference load: shift the addressed lane down, mask to size, extend from its MSB if signed
    function automatic logic [31:0] load_model(input logic [2:0] code, input int off, input logic [31:0] word);
        int          n;
        logic [31:0] v;
        logic [31:0] mask;
        n = size_bytes(code);
        v = word >> (8 * off);
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (!code[2] && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 2000) begin
            req_valid = 1'($urandom_range(0, 1));
            req_op    = 4'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            @(negedge clk);
            t++;
        end
        req_valid = 1'b0;
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            $display("[TB] %0d tests run, %0d failed", tests, failed);
            $fatal(1, "ready wait expired");
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdword, input int waits, input bit expect_rsp);
        int   n;
        int   off;
        bit   mis;
        bus_t b;
        rsp_t r;
        wait_ready();
        n   = size_bytes(op[2:0]);
        off = int'(addr[1:0]);
        mis = (off % n) != 0;
        b.addr   = addr - 32'(off);
        b.be     = 4'd0;
        b.wd     = 32'd0;
        b.wr     = op[3];
        b.waits  = waits;
        b.rdword = rdword;
        for (int k = 0; k < 4; k++) begin
            if (k >= off && k < off + n) b.be[k] = 1'b1;
            b.wd[8 * k +: 8] = wdata[8 * (k % n) +: 8];
        end
        r.mis   = mis;
        r.rdata = (mis || op[3]) ? 32'd0 : load_model(op[2:0], off, rdword);
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        r.cyc = mis ? cyc : cyc + waits + 1;
        if (!mis) bus_q.push_back(b);
        if (expect_rsp) rsp_q.push_back(r);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || !req_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // Bus slave: consumes expected bus cycles, stalls the planned number of cycles
    bus_t cur;
    bit   active = 1'b0;
    int   cnt    = 0;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            active      = 1'b0;
            cnt         = 0;
            waitrequest = 1'b0;
            readdata    = 32'd0;
        end else if (read || write) begin
            if (!active) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", {30'd0, read, write}, 32'd0);
                end else begin
                    cur    = bus_q.pop_front();
                    active = 1'b1;
                    cnt    = cur.waits;
                end
            end
            if (active) begin
                check("bus_read", {31'd0, read}, {31'd0, !cur.wr});
                check("bus_write", {31'd0, write}, {31'd0, cur.wr});
                check("bus_address", address, cur.addr);
                check("bus_byteenable", {28'd0, byteenable}, {28'd0, cur.be});
                if (cur.wr) check("bus_writedata", writedata, cur.wd);
                if (cnt > 0) begin
                    waitrequest = 1'b1;
                    readdata    = $urandom;
                    cnt--;
                end else begin
                    waitrequest = 1'b0;
                    readdata    = cur.rdword;
                    active      = 1'b0;
                end
            end
        end else begin
            if (active) begin
                check("bus_strobe_dropped", 32'd0, 32'd1);
                active = 1'b0;
            end
            waitrequest = 1'($urandom_range(0, 1));
            readdata    = $urandom;
        end
    end

    // Response monitor: pops on rsp_valid, otherwise checks that the result holds
    rsp_t       e;
    logic [31:0] last_rdata = 32'd0;
    logic        last_mis   = 1'b0;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            last_rdata = 32'd0;
            last_mis   = 1'b0;
        end else if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_misaligned", {31'd0, rsp_misaligned}, {31'd0, e.mis});
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                last_rdata = e.rdata;
                last_mis   = e.mis;
            end
        end else begin
            check("rsp_rdata_hold", rsp_rdata, last_rdata);
            check("rsp_mis_hold", {31'd0, rsp_misaligned}, {31'd0, last_mis});
        end
    end

    logic [3:0] op_v;
    int         waits_v;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_mis", {31'd0, rsp_misaligned}, 32'd0);
        check("reset_read", {31'd0, read}, 32'd0);
        check("reset_write", {31'd0, write}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_address", address, 32'd0);
        check("reset_writedata", writedata, 32'd0);
        check("reset_byteenable", {28'd0, byteenable}, 32'd0);
        reset = 1'b0;

        issue(4'b0000, 32'h0000_0104, 32'd0, 32'h1234_80FF, 0, 1'b1);
        drain();
        check("lb_rdata", rsp_rdata, 32'hFFFF_FFFF);
        check("lb_address", address, 32'h0000_0104);
        check("lb_be", {28'd0, byteenable}, 32'h1);

        issue(4'b0101, 32'h0000_0106, 32'd0, 32'h8001_0000, 3, 1'b1);
        drain();
        check("lhu_rdata", rsp_rdata, 32'h0000_8001);
        check("lhu_be", {28'd0, byteenable}, 32'hC);

        issue(4'b0001, 32'h0000_0106, 32'd0, 32'h8001_0000, 1, 1'b1);
        drain();
        check("lh_rdata", rsp_rdata, 32'hFFFF_8001);

        issue(4'b1000, 32'h0000_0203, 32'hAABB_CCDD, 32'd0, 0, 1'b1);
        drain();
        check("sb_address", address, 32'h0000_0200);
        check("sb_be", {28'd0, byteenable}, 32'h8);
        check("sb_writedata", writedata, 32'hDDDD_DDDD);
        check("sb_rdata", rsp_rdata, 32'd0);

        issue(4'b0011, 32'h0000_0102, 32'd0, 32'hFFFF_FFFF, 0, 1'b1);
        drain();
        check("lw_mis_flag", {31'd0, rsp_misaligned}, 32'd1);
        check("lw_mis_rdata", rsp_rdata, 32'd0);
        check("lw_mis_no_bus_addr", address, 32'h0000_0200);

        issue(4'b1011, 32'h0000_0300, 32'h1234_5678, 32'd0, 1000, 1'b0);
        repeat (3) @(negedge clk);
        check("sw_stall_write", {31'd0, write}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("sw_reset_write", {31'd0, write}, 32'd0);
        check("sw_reset_read", {31'd0, read}, 32'd0);
        check("sw_reset_ready", {31'd0, req_ready}, 32'd1);
        check("sw_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("sw_reset_ready_after", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 300; i++) begin
            op_v    = {1'($urandom_range(0, 1)), codes[$urandom_range(0, 4)]};
            waits_v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 3));
            issue(op_v, $urandom, $urandom, $urandom, waits_v, 1'b1);
        end
        drain();
        check("final_bus_q_empty", 32'(bus_q.size()), 32'd0);
        check("final_rsp_q_empty", 32'(rsp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
